aes_uart_stream_arbiter: RTL

- Parametrised, multi-channel successor to the two-path APB-to-UART bridge datapath.
- Accepts N_AES-bit blocks from N_CH concatenating APB controllers and arbitrates between them round-robin.
- Per block, either routes through an external combinational AES core with a programmable latency wait, or bypasses encryption.
- Serializes the result into DATA_WIDTH words for the UART controller and raises a refill request after every REQ_THRESHOLD UART FIFO pops.

---
 rtl/aes_uart_stream_arbiter_if.sv | 33 +++
 rtl/aes_uart_stream_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/aes_uart_stream_arbiter_if.sv
// Block-source, AES-core and UART-side signals of the stream arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface aes_uart_stream_arbiter_if #(
  parameter int N_CH       = 2,
  parameter int N_AES      = 128,
  parameter int DATA_WIDTH = 32
) ();
  localparam int GW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       blk_valid;
  logic [N_CH*N_AES-1:0] blk_data;
  logic [N_CH-1:0]       enc_en;
  logic [N_CH-1:0]       blk_ready;
  logic [N_AES-1:0]      aes_in;
  logic [N_AES-1:0]      aes_out;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  word_ready;
  logic                  word_pop;
  logic                  req;
  logic                  busy;
  logic [GW-1:0]         last_grant;

  modport slave (
    input  blk_valid, blk_data, enc_en, aes_out, word_ready, word_pop,
    output blk_ready, aes_in, word_valid, word_data, req, busy, last_grant
  );

  modport master (
    output blk_valid, blk_data, enc_en, aes_out, word_ready, word_pop,
    input  blk_ready, aes_in, word_valid, word_data, req, busy, last_grant
  );
endinterface

// File: rtl/aes_uart_stream_arbiter.sv
// Round-robin block arbiter with optional AES pass and MSW-first serialization
// toward the UART controller, plus a FIFO-refill request every REQ_THRESHOLD pops.
module aes_uart_stream_arbiter #(
  parameter int N_CH          = 2,
  parameter int N_AES         = 128,
  parameter int DATA_WIDTH    = 32,
  parameter int AES_LATENCY   = 5,
  parameter int REQ_THRESHOLD = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  aes_uart_stream_arbiter_if.slave  bus
);
  localparam int N_WORDS = N_AES / DATA_WIDTH;
  localparam int GW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WIW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int LCW     = (AES_LATENCY > 1) ? $clog2(AES_LATENCY) : 1;
  localparam int PCW     = (REQ_THRESHOLD > 1) ? $clog2(REQ_THRESHOLD) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ENC_WAIT = 2'd1;
  localparam logic [1:0] SERIAL   = 2'd2;

  logic [1:0]       state;
  logic [N_AES-1:0] blk_reg;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    last_grant_q;
  logic [GW-1:0]    grant_idx;
  logic             grant_found;
  logic [LCW-1:0]   wait_cnt;
  logic [WIW-1:0]   word_idx;
  logic [PCW-1:0]   pop_cnt;
  logic             req_q;
  int               cand;

  // rr_ptr holds the first channel to search, so it can reset to channel 0
  // while last_grant itself still resets to 0.
  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!grant_found && bus.blk_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    bus.blk_ready = '0;
    if (state == IDLE && grant_found) bus.blk_ready[grant_idx] = 1'b1;
  end

  assign bus.word_valid = (state == SERIAL);
  assign bus.word_data  = (state == SERIAL) ? blk_reg[N_AES-1 -: DATA_WIDTH] : '0;
  assign bus.aes_in     = (state == ENC_WAIT) ? blk_reg : '0;
  assign bus.busy       = (state != IDLE);
  assign bus.last_grant = last_grant_q;
  assign bus.req        = req_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= IDLE;
      blk_reg      <= '0;
      rr_ptr       <= '0;
      last_grant_q <= '0;
      wait_cnt     <= '0;
      word_idx     <= '0;
      pop_cnt      <= '0;
      req_q        <= 1'b0;
    end else begin
      // Pops are counted independently of the block FSM.
      if (bus.word_pop) begin
        if (pop_cnt == PCW'(REQ_THRESHOLD - 1)) begin
          pop_cnt <= '0;
          req_q   <= 1'b1;
        end else begin
          pop_cnt <= pop_cnt + 1'b1;
          req_q   <= 1'b0;
        end
      end else begin
        req_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_found) begin
            blk_reg      <= bus.blk_data[int'(grant_idx)*N_AES +: N_AES];
            last_grant_q <= grant_idx;
            rr_ptr       <= (grant_idx == GW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
            word_idx     <= '0;
            wait_cnt     <= LCW'(AES_LATENCY - 1);
            state        <= bus.enc_en[grant_idx] ? ENC_WAIT : SERIAL;
          end
        end
        ENC_WAIT: begin
          if (wait_cnt == '0) begin
            blk_reg <= bus.aes_out;
            state   <= SERIAL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SERIAL: begin
          if (bus.word_ready) begin
            blk_reg <= blk_reg << DATA_WIDTH;
            if (word_idx == WIW'(N_WORDS - 1)) begin
              word_idx <= '0;
              state    <= IDLE;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
